// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive buffer.
package uart_pkg;

  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned WORD_W     = BYTE_W * WORD_BYTES;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATHER = 2'd1,
    RESP   = 2'd2
  } rxbuf_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Single-clock byte FIFO with registered occupancy flags.
// dout_c is the head entry, readable in the same cycle it is popped.
module byte_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH  = 16,
  localparam int unsigned ADDR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [BYTE_W-1:0] din,
  output logic [BYTE_W-1:0] dout_c,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              push_ok, pop_ok;

  // Flags are evaluated at cycle start, so a full FIFO refuses a push even when popping.
  always_comb begin
    push_ok  = push & ~full_q;
    pop_ok   = pop & ~empty_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + ADDR_W'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == CNT_W'(DEPTH));
    empty_d = (count_d == CNT_W'(0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout_c = mem_q[rd_ptr_q];
  assign count  = count_q;
  assign full   = full_q;
  assign empty  = empty_q;

endmodule

// File: rtl/uart_rx_buffer.sv
// Buffers received UART bytes and answers CPU input requests with one byte
// or one big-endian 32-bit word (first received byte in the MSBs).
module uart_rx_buffer
  import uart_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              req,
  input  logic              req_word,
  output logic              busy,
  output logic              resp_valid,
  output logic [WORD_W-1:0] resp_data,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              overflow
);

  localparam int unsigned NEED_W = 3;

  rxbuf_state_t      state_q, state_d;
  logic [NEED_W-1:0] need_q, need_d;
  logic [NEED_W-1:0] got_q, got_d;
  logic [WORD_W-1:0] acc_q, acc_d;
  logic [WORD_W-1:0] resp_data_q, resp_data_d;
  logic              resp_valid_q, resp_valid_d;
  logic              busy_q, busy_d;
  logic              overflow_q, overflow_d;

  logic              fifo_pop_c;
  logic              fifo_full;
  logic              fifo_empty;
  logic [BYTE_W-1:0] fifo_dout_c;

  byte_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push   (in_valid),
    .pop    (fifo_pop_c),
    .din    (in_data),
    .dout_c (fifo_dout_c),
    .count  (count),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Request FSM: gather need bytes (1 or 4) from the FIFO, then present them for one cycle.
  always_comb begin
    state_d      = state_q;
    need_d       = need_q;
    got_d        = got_q;
    acc_d        = acc_q;
    fifo_pop_c   = 1'b0;
    overflow_d   = overflow_q | (in_valid & fifo_full);
    case (state_q)
      IDLE: begin
        if (req) begin
          need_d  = req_word ? NEED_W'(WORD_BYTES) : NEED_W'(1);
          got_d   = '0;
          acc_d   = '0;
          state_d = GATHER;
        end
      end
      GATHER: begin
        if (!fifo_empty) begin
          fifo_pop_c = 1'b1;
          acc_d      = {acc_q[WORD_W-BYTE_W-1:0], fifo_dout_c};
          got_d      = got_q + NEED_W'(1);
          if (got_q == need_q - NEED_W'(1)) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    resp_valid_d = (state_d == RESP);
    resp_data_d  = (state_d == RESP) ? acc_d : resp_data_q;
    busy_d       = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      need_q       <= '0;
      got_q        <= '0;
      acc_q        <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      need_q       <= need_d;
      got_q        <= got_d;
      acc_q        <= acc_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      busy_q       <= busy_d;
      overflow_q   <= overflow_d;
    end
  end

  assign busy       = busy_q;
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign empty      = fifo_empty;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_uart_rx_buffer.sv
// Self-checking bench for uart_rx_buffer: directed scenarios plus randomized
// push/request traffic against a byte-queue reference model.
module tb_uart_rx_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             req;
  logic             req_word;
  logic             busy;
  logic             resp_valid;
  logic [31:0]      resp_data;
  logic [CNT_W-1:0] count;
  logic             empty;
  logic             overflow;

  int checks = 0;
  int errors = 0;
  logic [7:0] mq[$];

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .req        (req),
    .req_word   (req_word),
    .busy       (busy),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .count      (count),
    .empty      (empty),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    mq.delete();
  endtask

  task automatic push_byte(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    tick();
    in_valid = 1'b0;
  endtask

  // Issue a request and wait (bounded) for its response; exp_lat < 0 skips the latency check.
  task automatic do_req(input logic word, input int exp_lat, input logic [31:0] exp_data,
                        input string tag);
    int n;
    int bound;
    logic seen;
    n     = 0;
    seen  = 1'b0;
    bound = (exp_lat < 0) ? 400 : exp_lat + 20;
    req      = 1'b1;
    req_word = word;
    while (n < bound && !seen) begin
      tick();
      req = 1'b0;
      n++;
      if (resp_valid) seen = 1'b1;
    end
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      if (exp_lat >= 0) chk({tag, "_lat"}, 32'(n), 32'(exp_lat));
      chk({tag, "_data"}, resp_data, exp_data);
      tick();
      chk({tag, "_strobe"}, 32'(resp_valid), 32'd0);
      chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    end
  endtask

  function automatic logic [31:0] model_take(input int nbytes);
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < nbytes; i++) w = {w[23:0], mq.pop_front()};
    return w;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_w;
    logic        saw;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; req = 1'b0; req_word = 1'b0;
    #1;

    // Reset state
    do_reset();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);

    // Word request with bytes already buffered
    push_byte(8'h12); push_byte(8'h34); push_byte(8'h56); push_byte(8'h78);
    chk("t2_count4", 32'(count), 32'd4);
    do_req(1'b1, 5, 32'h12345678, "t2_word");
    chk("t2_count0", 32'(count), 32'd0);

    // Byte request on empty FIFO waits for the byte
    req = 1'b1; req_word = 1'b0;
    tick();
    req = 1'b0;
    saw = 1'b0;
    repeat (10) begin
      tick();
      if (resp_valid) saw = 1'b1;
    end
    chk("t3_no_resp_while_empty", 32'(saw), 32'd0);
    chk("t3_busy_wait", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 8'hA5;
    tick();
    in_valid = 1'b0;
    tick();
    chk("t3_resp_at_w2", 32'(resp_valid), 32'd1);
    chk("t3_data", resp_data, 32'h000000A5);
    tick(); tick(); tick();
    chk("t3_data_hold", resp_data, 32'h000000A5);

    // Fill past capacity: 17th byte dropped, overflow sticky
    for (int i = 0; i <= 16; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 1'b0;
    chk("t4_count_full", 32'(count), 32'(DEPTH));
    chk("t4_overflow", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) do_req(1'b0, 2, 32'(i), $sformatf("t4_byte%0d", i));
    chk("t4_empty_after", 32'(empty), 32'd1);
    chk("t4_overflow_sticky", 32'(overflow), 32'd1);

    // Concurrent pushes and word requests across pointer wrap
    do_reset();
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          push_byte(8'(i));
          repeat ($urandom_range(0, 2)) tick();
        end
      end
      begin
        for (int j = 0; j < 10; j++) begin
          exp_w = {8'(4*j), 8'(4*j+1), 8'(4*j+2), 8'(4*j+3)};
          do_req(1'b1, -1, exp_w, $sformatf("t5_word%0d", j));
        end
      end
    join
    chk("t5_count0", 32'(count), 32'd0);
    chk("t5_no_overflow", 32'(overflow), 32'd0);

    // Randomized bursts and requests against the queue model
    for (int it = 0; it < 40; it++) begin
      int k;
      int need;
      logic w;
      k = $urandom_range(0, DEPTH - mq.size());
      for (int b = 0; b < k; b++) begin
        logic [7:0] v;
        v = 8'($urandom);
        mq.push_back(v);
        push_byte(v);
      end
      w = 1'($urandom_range(0, 1));
      need = w ? 4 : 1;
      if (mq.size() >= need) begin
        exp_w = model_take(need);
        do_req(w, w ? 5 : 2, exp_w, $sformatf("rnd%0d", it));
      end
      chk($sformatf("rnd%0d_count", it), 32'(count), 32'(mq.size()));
    end
    chk("rnd_no_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a word gather
    do_reset();
    push_byte(8'hDE); push_byte(8'hAD); push_byte(8'hBE); push_byte(8'hEF);
    req = 1'b1; req_word = 1'b1;
    tick();
    req = 1'b0;
    tick(); tick();
    chk("t6_count_after_2pops", 32'(count), 32'd2);
    rst = 1'b1;
    saw = 1'b0;
    tick();
    if (resp_valid) saw = 1'b1;
    tick();
    if (resp_valid) saw = 1'b1;
    rst = 1'b0;
    repeat (6) begin
      tick();
      if (resp_valid) saw = 1'b1;
    end
    chk("t6_no_resp", 32'(saw), 32'd0);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_count", 32'(count), 32'd0);
    chk("t6_empty", 32'(empty), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
